// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: ID-stage load-use / MULT-DIV stall and branch flush control
// with a saturating stall-cycle counter.
module hazard_stall_ctrl #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6,
  parameter int PERF_W     = 32
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [4:0]        ID_rs,
  input  logic [4:0]        ID_rt,
  input  logic              ID_uses_rt,
  input  logic              EX_MemRead,
  input  logic [4:0]        EX_rt,
  input  logic              ID_md_start,
  input  logic              ID_md_use,
  input  logic              ID_branch_tk,
  input  logic              ID_jump,
  output logic              PCWrite,
  output logic              IF_Flush,
  output logic              ID_EX_Bubble,
  output logic              md_busy,
  output logic [PERF_W-1:0] stall_cycles
);
  typedef enum logic {RUN, MD_BUSY} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  logic load_use, md_hazard, stall;
  always_comb begin
    load_use  = EX_MemRead && (EX_rt != 5'd0) &&
                ((EX_rt == ID_rs) || (ID_uses_rt && (EX_rt == ID_rt)));
    md_hazard = (state_q == MD_BUSY) && (ID_md_use || ID_md_start);
    stall     = load_use || md_hazard;
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    if (state_q == RUN) begin
      if (ID_md_start && !stall) begin
        state_d    = MD_BUSY;
        busy_cnt_d = CNT_W'(MD_LATENCY - 1);
      end
    end else begin
      busy_cnt_d = busy_cnt_q - 1'b1;
      state_d    = (busy_cnt_q == CNT_W'(1)) ? RUN : MD_BUSY;
    end
    stall_cycles_d = (stall && stall_cycles_q != '1) ? stall_cycles_q + 1'b1 : stall_cycles_q;
  end
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      busy_cnt_q     <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      busy_cnt_q     <= busy_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end
  // Reset overrides everything so IF/ID and ID/EX are held empty while rst_n is low.
  assign PCWrite      = rst_n && !stall;
  assign IF_Flush     = !rst_n || (!stall && (ID_branch_tk || ID_jump));
  assign ID_EX_Bubble = !rst_n || stall;
  assign md_busy      = rst_n && (state_q == MD_BUSY);
  assign stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed + random stimulus, expectations from a cycle-level
// reference model queued to a negedge monitor.
module tb_hazard_stall_ctrl;
  localparam int LAT = 4;
  localparam int CW  = 3;
  localparam int PW  = 4;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [4:0] ID_rs = '0, ID_rt = '0, EX_rt = '0;
  logic ID_uses_rt = 0, EX_MemRead = 0, ID_md_start = 0, ID_md_use = 0, ID_branch_tk = 0, ID_jump = 0;
  logic PCWrite, IF_Flush, ID_EX_Bubble, md_busy;
  logic [PW-1:0] stall_cycles;
  hazard_stall_ctrl #(.MD_LATENCY(LAT), .CNT_W(CW), .PERF_W(PW)) dut (
    .clock(clk), .rst_n(rst_n), .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_uses_rt(ID_uses_rt),
    .EX_MemRead(EX_MemRead), .EX_rt(EX_rt), .ID_md_start(ID_md_start), .ID_md_use(ID_md_use),
    .ID_branch_tk(ID_branch_tk), .ID_jump(ID_jump), .PCWrite(PCWrite), .IF_Flush(IF_Flush),
    .ID_EX_Bubble(ID_EX_Bubble), .md_busy(md_busy), .stall_cycles(stall_cycles));
  always #5 clk = ~clk;
  typedef struct {logic pcw; logic fl; logic bub; logic busy; logic [PW-1:0] cnt;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0;
  int md_rem = 0, scnt = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", n, a, e, $time);
    end
  endtask
  // Model: md_rem counts remaining busy cycles; scnt is the saturating stall count.
  task automatic step(input logic r, input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                      input logic [4:0] rt, input logic urt, input logic ms, input logic mu,
                      input logic bt, input logic j);
    exp_t e;
    logic lu, st;
    @(posedge clk); #1;
    rst_n = r; EX_MemRead = mr; EX_rt = ert; ID_rs = rs; ID_rt = rt; ID_uses_rt = urt;
    ID_md_start = ms; ID_md_use = mu; ID_branch_tk = bt; ID_jump = j;
    if (!r) begin
      md_rem = 0; scnt = 0;
      e.pcw = 0; e.fl = 1; e.bub = 1; e.busy = 0; e.cnt = '0;
    end else begin
      lu = mr && ert != 0 && (ert == rs || (urt && ert == rt));
      st = lu || (md_rem > 0 && (mu || ms));
      e.pcw = !st; e.fl = !st && (bt || j); e.bub = st; e.busy = md_rem > 0; e.cnt = PW'(scnt);
      if (md_rem > 0) md_rem--;
      else if (ms && !st) md_rem = LAT - 1;
      if (st && scnt < 2**PW - 1) scnt++;
    end
    q.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("PCWrite", 32'(PCWrite), 32'(e.pcw));
        chk("IF_Flush", 32'(IF_Flush), 32'(e.fl));
        chk("ID_EX_Bubble", 32'(ID_EX_Bubble), 32'(e.bub));
        chk("md_busy", 32'(md_busy), 32'(e.busy));
        chk("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
      end
    end
  end
  initial begin : stim
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    // load-use on rs, then released
    step(1, 1, 8, 8, 3, 0, 0, 0, 0, 0);
    step(1, 0, 0, 8, 3, 0, 0, 0, 0, 0);
    // load into $zero never stalls; load-use through rt only when rt is read
    step(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
    step(1, 1, 9, 1, 9, 0, 0, 0, 0, 0);
    step(1, 1, 9, 1, 9, 1, 0, 0, 0, 0);
    // MULT issue, MFLO waits out the window then issues
    step(1, 0, 0, 1, 2, 0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 2, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    // taken branch alone, then coincident with load-use, then released
    step(1, 0, 0, 1, 2, 0, 0, 0, 1, 0);
    step(1, 1, 5, 5, 2, 0, 0, 0, 1, 0);
    step(1, 0, 0, 5, 2, 0, 0, 0, 1, 0);
    step(1, 0, 0, 5, 2, 0, 0, 0, 0, 1);
    // back-to-back MULTs: second waits then re-enters busy; branch flows during window
    step(1, 0, 0, 1, 2, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1, 2, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    // reset mid-window aborts it
    step(1, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 2, 0, 0, 1, 0, 0);
    // 20 consecutive stalls saturate the counter
    for (int i = 0; i < 20; i++) step(1, 1, 8, 8, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 7) == 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
